ysyx_23060096_writeback_unit: RTL and testbench
===============================================

Name: ysyx_23060096_writeback_unit

Overview:
- Write-side controller for the NPC integer register file.
- Accepts completed results from the ALU and the LSU over valid/ready, arbitrates them onto the single register-file write port, and registers that port (rf_wen/rf_waddr/rf_wdata).
- Keeps a per-register pending-write scoreboard so decode can stall on RAW/WAW hazards.

Parameters:
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- STARVE_LIMIT, 4, consecutive LSU wait cycles before the LSU takes priority over the ALU; range 1..15.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- iss_valid  in  1  decode issues an instruction that writes rd this cycle.
- iss_rd  in  ADDR_WIDTH  destination of the issued instruction.
- rs1, rs2, rd_q  in  ADDR_WIDTH  indices queried by decode.
- rs1_busy, rs2_busy, rd_busy  out  1  the queried register has a pending write (combinational).
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted.
- alu_rd  in  ADDR_WIDTH  ALU destination.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_valid, lsu_ready, lsu_rd, lsu_data  same as the alu_* ports, for load results.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register-file write address (registered).
- rf_wdata  out  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset (rstn low at the clk edge):
  - scoreboard all 0, starve counter 0, rf_wen 0, rf_waddr 0, rf_wdata 0.
  - alu_ready and lsu_ready are 0 while rstn is low.
  - Reset mid-transfer discards any accepted but not yet written result.
- Scoreboard:
  - pending[ADDR_WIDTH-bit index] is set at the edge where iss_valid=1 and iss_rd!=0.
  - It is cleared at the edge where rf_wen=1 and rf_waddr matches, i.e. the same edge at which the register file captures the data.
  - Same index set and cleared on the same edge: set wins.
  - pending[0] is always 0.
  - Decode must not issue while rd_busy=1 (WAW), so there is at most one outstanding write per register. This is an SVA-checked assumption: iss_valid & pending[iss_rd] is an error.
- Busy outputs: xx_busy = pending[xx]. Index 0 always reads not busy.
- Arbitration: at most one grant per cycle.
  - Default priority: ALU over LSU.
  - starve_cnt increments each cycle lsu_valid=1 and the LSU is not granted (saturating), and resets to 0 when the LSU is granted or lsu_valid=0.
  - When starve_cnt >= STARVE_LIMIT, the LSU has priority.
  - Ready is asserted only to the granted source. Grant depends on valid (ready may depend on valid).
  - Once valid is high, the source holds valid/rd/data stable until ready.
- Write port:
  - On a grant at edge E1: rf_wen<=1, rf_waddr<=rd, rf_wdata<=data.
  - With no grant: rf_wen<=0 and addr/data hold their values.
  - The register file writes at E2, and pending clears at E2.
  - Result-to-architectural-state latency is 2 edges.
- x0 results:
  - A grant with rd=0 is accepted (ready=1) but rf_wen<=0.
  - The scoreboard is unaffected.
- Throughput: one write per cycle, back-to-back grants with no bubble.
- Simultaneous alu_valid and lsu_valid for the same rd is illegal given the WAW rule; it is SVA-flagged.

Optional Feature:
- Macro: YSYX_23060096_WB_BYPASS_EN.
- Defined:
  - A query index matching rf_waddr while rf_wen=1 (index != 0) reports busy=0.
  - Extra outputs rs1_fwd/rs2_fwd (1 bit) and fwd_data (DATA_WIDTH = rf_wdata) let decode take the value one cycle earlier.
- Undefined:
  - busy follows pending only.
  - The fwd ports are absent.

Decomposition:
- Package ysyx_23060096_pkg holds:
  - the REG_ADDR_W/XLEN constants,
  - a typedef for the writeback request {rd, data},
  - the STARVE_CNT_W constant (4).
- Sub-module ysyx_23060096_wb_arb contains the two-source priority/starvation arbiter (starve counter, grant logic).
- The top-level module holds the scoreboard and the write-port registers.

Test Plan:
- Reset:
  - Stimulus: hold rstn=0 for 3 cycles with alu_valid=1.
  - Expected: rf_wen=0, alu_ready=0, and every busy output 0.
  - Stimulus: release rstn.
  - Expected: the ALU is granted next cycle.
- Basic write:
  - Stimulus: issue rd=5; 2 cycles later alu_valid, rd=5, data=0xDEADBEEF.
  - Expected:
    - rs1_busy(5)=1 from the edge after issue.
    - rf_wen=1, waddr=5, wdata=0xDEADBEEF one edge after accept.
    - busy cleared the following edge.
- Contention/starvation with STARVE_LIMIT=4:
  - Stimulus: alu_valid continuously on rd 1..8 while lsu_valid on rd=9.
  - Expected: the LSU is granted in exactly the 5th cycle of waiting, and the ALU stalls that cycle.
- x0:
  - Stimulus: alu_valid with rd=0, data=0x1234.
  - Expected: alu_ready=1, rf_wen stays 0, and rd_busy(0)=0 throughout.
- Set/clear collision:
  - Stimulus: rf_wen is writing rd=7 on the same edge a new issue of rd=7 arrives (after the pending clear is legal).
  - Expected: pending[7]=1 after the edge.
- Bypass (macro on):
  - Stimulus: query rs1=3 while rf_wen=1, waddr=3, wdata=0x55.
  - Expected: rs1_busy=0, rs1_fwd=1, fwd_data=0x55.
  - Expected with the macro off: rs1_busy=1 in the same cycle.

Source files
------------

// File: rtl/ysyx_23060096_pkg.sv
// ysyx_23060096_pkg: shared widths, counter width and writeback request type
// Exports REG_ADDR_W (register index width), XLEN (data width),
// STARVE_CNT_W (LSU starvation counter width) and wb_req_t {rd, data}.
package ysyx_23060096_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int STARVE_CNT_W = 4;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/ysyx_23060096_wb_arb.sv
// ysyx_23060096_wb_arb: two-source ALU/LSU arbiter with LSU starvation escape
// Ports: clk, rstn (sync, active-low), alu_valid/lsu_valid in,
// alu_gnt/lsu_gnt out (at most one high, both low in reset).
module ysyx_23060096_wb_arb
  import ysyx_23060096_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_gnt,
  output logic lsu_gnt
);
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic lsu_pri;
  always_comb begin
    lsu_pri = starve_cnt >= STARVE_CNT_W'(STARVE_LIMIT);
    lsu_gnt = rstn & lsu_valid & (lsu_pri | ~alu_valid);
    alu_gnt = rstn & alu_valid & ~lsu_gnt;
  end
  // Counts cycles the LSU has waited with a valid result; saturates at all-ones.
  always_ff @(posedge clk)
    if (!rstn || !lsu_valid || lsu_gnt) starve_cnt <= '0;
    else if (~&starve_cnt) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/ysyx_23060096_writeback_unit.sv
// ysyx_23060096_writeback_unit: register-file write port arbiter and pending-write scoreboard
// Ports: clk, rstn (sync, active-low); iss_valid/iss_rd mark a pending write;
// rs1/rs2/rd_q queries -> rs1_busy/rs2_busy/rd_busy; alu_* and lsu_* result
// channels (valid/ready/rd/data); registered rf_wen/rf_waddr/rf_wdata.
// Optional macro YSYX_23060096_WB_BYPASS_EN: a register being written this
// cycle reads not-busy and rs1_fwd/rs2_fwd/fwd_data expose the in-flight value.
module ysyx_23060096_writeback_unit
  import ysyx_23060096_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd_q,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef YSYX_23060096_WB_BYPASS_EN
  ,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  logic [NREG-1:0] pending, set_mask, clr_mask;
  logic alu_gnt, lsu_gnt, gnt;
  logic [ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_data;
  ysyx_23060096_wb_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .alu_valid(alu_valid),
    .lsu_valid(lsu_valid),
    .alu_gnt  (alu_gnt),
    .lsu_gnt  (lsu_gnt)
  );
  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;
  // clr_mask doubles as the "being written this cycle" vector; rf_wen is
  // never raised for x0, so bit 0 of either mask is never set.
  always_comb begin
    gnt = alu_gnt | lsu_gnt;
    w_rd = lsu_gnt ? lsu_rd : alu_rd;
    w_data = lsu_gnt ? lsu_data : alu_data;
    set_mask = (iss_valid && iss_rd != '0) ? NREG'(1) << iss_rd : '0;
    clr_mask = rf_wen ? NREG'(1) << rf_waddr : '0;
`ifdef YSYX_23060096_WB_BYPASS_EN
    rs1_busy = pending[rs1] & ~clr_mask[rs1];
    rs2_busy = pending[rs2] & ~clr_mask[rs2];
    rd_busy = pending[rd_q] & ~clr_mask[rd_q];
    rs1_fwd = clr_mask[rs1];
    rs2_fwd = clr_mask[rs2];
    fwd_data = rf_wdata;
`else
    rs1_busy = pending[rs1];
    rs2_busy = pending[rs2];
    rd_busy = pending[rd_q];
`endif
  end
  // Set is applied after clear so a re-issue on the retiring edge keeps the bit.
  always_ff @(posedge clk)
    if (!rstn) begin
      pending <= '0;
      rf_wen <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      rf_wen <= gnt && w_rd != '0;
      if (gnt) begin
        rf_waddr <= w_rd;
        rf_wdata <= w_data;
      end
    end
  // Re-issuing a register is only legal on the edge where its write retires.
  a_waw_issue: assert property (@(posedge clk) disable iff (!rstn)
    !(iss_valid && iss_rd != '0 && pending[iss_rd] && !clr_mask[iss_rd]));
  a_same_rd: assert property (@(posedge clk) disable iff (!rstn)
    !(alu_valid && lsu_valid && alu_rd == lsu_rd && alu_rd != '0));
endmodule

// File: tb/tb_ysyx_23060096_writeback_unit.sv
// tb_ysyx_23060096_writeback_unit: directed table and sequence checks for the writeback unit
module tb_ysyx_23060096_writeback_unit;
  logic clk = 1'b0, rstn = 1'b0, iss_valid = 1'b0, alu_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0] iss_rd = '0, rs1 = '0, rs2 = '0, rd_q = '0, alu_rd = '0, lsu_rd = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic rs1_busy, rs2_busy, rd_busy, alu_ready, lsu_ready, rf_wen;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
`ifdef YSYX_23060096_WB_BYPASS_EN
  logic rs1_fwd, rs2_fwd;
  logic [31:0] fwd_data;
`endif
  int checks = 0, failures = 0;
  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic ear; logic elr; logic ewen; logic [4:0] ewa; logic [31:0] ewd;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  ysyx_23060096_writeback_unit dut (
    .clk(clk), .rstn(rstn), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rd_q(rd_q),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef YSYX_23060096_WB_BYPASS_EN
    , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic ear, input logic elr, input logic ewen,
                              input logic [4:0] ewa, input logic [31:0] ewd);
    mk = '{av, ard, ad, lv, lrd, ld, ear, elr, ewen, ewa, ewd};
  endfunction

  initial begin
    // Starvation: LSU waits 4 cycles, wins the 5th, ALU rd5 stalls one cycle.
    tbl[0]  = mk(1, 1, 32'hA000_0001, 1, 9, 32'h99, 1, 0, 1, 1, 32'hA000_0001);
    tbl[1]  = mk(1, 2, 32'hA000_0002, 1, 9, 32'h99, 1, 0, 1, 2, 32'hA000_0002);
    tbl[2]  = mk(1, 3, 32'hA000_0003, 1, 9, 32'h99, 1, 0, 1, 3, 32'hA000_0003);
    tbl[3]  = mk(1, 4, 32'hA000_0004, 1, 9, 32'h99, 1, 0, 1, 4, 32'hA000_0004);
    tbl[4]  = mk(1, 5, 32'hA000_0005, 1, 9, 32'h99, 0, 1, 1, 9, 32'h99);
    tbl[5]  = mk(1, 5, 32'hA000_0005, 0, 0, 32'h0,  1, 0, 1, 5, 32'hA000_0005);
    tbl[6]  = mk(1, 6, 32'hA000_0006, 0, 0, 32'h0,  1, 0, 1, 6, 32'hA000_0006);
    tbl[7]  = mk(1, 7, 32'hA000_0007, 0, 0, 32'h0,  1, 0, 1, 7, 32'hA000_0007);
    tbl[8]  = mk(1, 8, 32'hA000_0008, 0, 0, 32'h0,  1, 0, 1, 8, 32'hA000_0008);
    tbl[9]  = mk(0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 8, 32'hA000_0008);
    tbl[10] = mk(0, 0, 32'h0,         1, 10, 32'h10A, 0, 1, 1, 10, 32'h10A);
    tbl[11] = mk(1, 11, 32'hB,        1, 12, 32'hC, 1, 0, 1, 11, 32'hB);
    tbl[12] = mk(0, 0, 32'h0,         1, 12, 32'hC, 0, 1, 1, 12, 32'hC);

    // Reset held 3 cycles with an ALU result and an issue pending.
    alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
    iss_valid = 1; iss_rd = 4; rs1 = 4; rs2 = 2; rd_q = 1;
    repeat (3) begin
      tick();
      chk("rst_wen", 32'(rf_wen), 0);
      chk("rst_alu_ready", 32'(alu_ready), 0);
      chk("rst_busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 0);
    end
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", rf_wdata, 0);
    rstn = 1; iss_valid = 0;
    #1 chk("rel_alu_ready", 32'(alu_ready), 1);
    tick();
    chk("rel_wen", 32'(rf_wen), 1);
    chk("rel_waddr", 32'(rf_waddr), 2);
    chk("rel_wdata", rf_wdata, 32'h22);

    // Basic write of rd5.
    alu_valid = 0; iss_valid = 1; iss_rd = 5; rs1 = 5;
    #1 chk("bw_busy_pre", 32'(rs1_busy), 0);
    tick();
    iss_valid = 0;
    #1 chk("bw_busy_issued", 32'(rs1_busy), 1);
    tick();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 chk("bw_alu_ready", 32'(alu_ready), 1);
    chk("bw_busy_accept", 32'(rs1_busy), 1);
    tick();
    alu_valid = 0;
    chk("bw_wen", 32'(rf_wen), 1);
    chk("bw_waddr", 32'(rf_waddr), 5);
    chk("bw_wdata", rf_wdata, 32'hDEADBEEF);
`ifdef YSYX_23060096_WB_BYPASS_EN
    #1 chk("bw_busy_write", 32'(rs1_busy), 0);
`else
    #1 chk("bw_busy_write", 32'(rs1_busy), 1);
`endif
    tick();
    chk("bw_wen_off", 32'(rf_wen), 0);
    chk("bw_waddr_hold", 32'(rf_waddr), 5);
    chk("bw_busy_clear", 32'(rs1_busy), 0);

    // Arbitration table.
    for (int i = 0; i < 13; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      #1;
      chk($sformatf("arb%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].ear));
      chk($sformatf("arb%0d_lsu_ready", i), 32'(lsu_ready), 32'(tbl[i].elr));
      tick();
      chk($sformatf("arb%0d_wen", i), 32'(rf_wen), 32'(tbl[i].ewen));
      chk($sformatf("arb%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].ewa));
      chk($sformatf("arb%0d_wdata", i), rf_wdata, tbl[i].ewd);
    end
    alu_valid = 0; lsu_valid = 0;

    // x0 result: accepted, never written, never busy.
    tick();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; iss_valid = 1; iss_rd = 0; rd_q = 0;
    #1 chk("x0_alu_ready", 32'(alu_ready), 1);
    chk("x0_busy_a", 32'(rd_busy), 0);
    tick();
    alu_valid = 0; iss_valid = 0;
    chk("x0_wen", 32'(rf_wen), 0);
    chk("x0_busy_b", 32'(rd_busy), 0);
    tick();
    chk("x0_busy_c", 32'(rd_busy), 0);

    // Set/clear collision on rd7.
    iss_valid = 1; iss_rd = 7; rd_q = 7;
    #1 chk("col_busy_pre", 32'(rd_busy), 0);
    tick();
    iss_valid = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    #1 chk("col_alu_ready", 32'(alu_ready), 1);
    tick();
    alu_valid = 0; iss_valid = 1; iss_rd = 7;
    chk("col_wen", 32'(rf_wen), 1);
    chk("col_waddr", 32'(rf_waddr), 7);
    tick();
    iss_valid = 0;
    chk("col_busy_after", 32'(rd_busy), 1);
    chk("col_wen_off", 32'(rf_wen), 0);
    tick();
    chk("col_busy_hold", 32'(rd_busy), 1);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
    tick();
    alu_valid = 0;
    tick();
    chk("col_busy_retired", 32'(rd_busy), 0);

    // Same-cycle query of the register being written.
    iss_valid = 1; iss_rd = 3;
    tick();
    iss_valid = 0; alu_valid = 1; alu_rd = 3; alu_data = 32'h55;
    tick();
    alu_valid = 0; rs1 = 3; rs2 = 4;
    chk("byp_wen", 32'(rf_wen), 1);
    chk("byp_wdata", rf_wdata, 32'h55);
`ifdef YSYX_23060096_WB_BYPASS_EN
    #1 chk("byp_rs1_busy", 32'(rs1_busy), 0);
    chk("byp_rs1_fwd", 32'(rs1_fwd), 1);
    chk("byp_rs2_fwd", 32'(rs2_fwd), 0);
    chk("byp_fwd_data", fwd_data, 32'h55);
`else
    #1 chk("byp_rs1_busy", 32'(rs1_busy), 1);
`endif
    tick();
    chk("byp_busy_clear", 32'(rs1_busy), 0);

    // Reset with a result in flight discards it and the scoreboard.
    iss_valid = 1; iss_rd = 6; rd_q = 6;
    tick();
    iss_valid = 0;
    #1 chk("mid_busy_set", 32'(rd_busy), 1);
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66; rstn = 0;
    #1 chk("mid_alu_ready", 32'(alu_ready), 0);
    tick();
    chk("mid_wen", 32'(rf_wen), 0);
    chk("mid_busy_clr", 32'(rd_busy), 0);
    rstn = 1; alu_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
